instr_fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_pc_next.sv | 22 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the main decoder: data width,
// major opcodes, fetch FSM states and fault codes.
package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes seen by the decoder (instr[6:0])
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Fetch FSM states
    typedef enum logic [2:0] {
        FS_BOOT  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_e;

    // Sticky fault codes
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_TIMEOUT  = 2'b01;
    localparam logic [1:0] FC_MISALIGN = 2'b10;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC computation for a retiring instruction: taken branch goes to
// pc + imm_b, everything else falls through to pc + 4 (both wrap mod 2^32).
module fetch_pc_next
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_b,
    input  logic            branch,
    input  logic            zero,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic taken;

    assign taken      = branch & zero;
    assign target     = taken ? (pc + imm_b) : (pc + 32'd4);
    // Only a branch offset can break alignment, but checking the final
    // target keeps the rule simple and uniform.
    assign misaligned = |target[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction for the decoder until retire, and latches a sticky
// fault on memory timeout or a misaligned branch target.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] imm_b,
    output logic        fault,
    output logic [1:0]  fault_code
);

    // Counter holds 0..TIMEOUT_CYCLES-1 (value k-1 during WAIT cycle k)
    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    fetch_state_e  state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   instr_reg, instr_next;
    logic [1:0]    fault_code_reg, fault_code_next;

    logic [31:0]   target;
    logic          misaligned;

    fetch_pc_next u_pc_next (
        .pc         (pc_reg),
        .imm_b      (imm_b),
        .branch     (branch),
        .zero       (zero),
        .target     (target),
        .misaligned (misaligned)
    );

    // Next-state logic: acks only matter in REQ/WAIT, retire only in HOLD,
    // and FAULT holds everything until reset.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pc_next         = pc_reg;
        instr_next      = instr_reg;
        fault_code_next = fault_code_reg;
        case (state_reg)
            FS_BOOT: state_next = FS_REQ;
            FS_REQ: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = FS_HOLD;
                end else begin
                    cnt_next   = '0;
                    state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = FS_HOLD;
                end else if (cnt_reg == CNT_LAST) begin
                    fault_code_next = FC_TIMEOUT;
                    state_next      = FS_FAULT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FS_HOLD: begin
                if (instr_ready) begin
                    if (misaligned) begin
                        fault_code_next = FC_MISALIGN;
                        state_next      = FS_FAULT;
                    end else begin
                        pc_next    = target;
                        state_next = FS_REQ;
                    end
                end
            end
            FS_FAULT: state_next = FS_FAULT;
            default:  state_next = FS_BOOT;
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= FS_BOOT;
            cnt_reg        <= '0;
            pc_reg         <= RESET_PC;
            instr_reg      <= '0;
            fault_code_reg <= FC_NONE;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pc_reg         <= pc_next;
            instr_reg      <= instr_next;
            fault_code_reg <= fault_code_next;
        end
    end

    assign imem_req    = (state_reg == FS_REQ);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign opcode      = instr_reg[6:0];
    assign instr_valid = (state_reg == FS_HOLD);
    assign fault       = (state_reg == FS_FAULT);
    assign fault_code  = fault_code_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the stimulus side plays memory and
// downstream, pushes each expected held instruction into a queue, and a
// separate monitor pops and compares whenever instr_valid rises.
module tb_instr_fetch_unit;

    localparam int          T   = 6;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic [31:0] imm_b;
    logic        fault;
    logic [1:0]  fault_code;

    instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch      (branch),
        .zero        (zero),
        .imm_b       (imm_b),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},     pc, RPC);
        chk({tag, "_instr"},  instr, 32'h0);
        chk({tag, "_opcode"}, {25'h0, opcode}, 32'h0);
        chk({tag, "_valid"},  {31'h0, instr_valid}, 32'h0);
        chk({tag, "_req"},    {31'h0, imem_req}, 32'h0);
        chk({tag, "_fault"},  {31'h0, fault}, 32'h0);
        chk({tag, "_code"},   {30'h0, fault_code}, 32'h0);
    endtask

    // Called at a falling edge; returns once imem_req is seen high (bounded).
    task automatic wait_req(output bit ok);
        ok = imem_req;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                @(negedge clk);
                ok = imem_req;
            end
        end
    endtask

    // Serve one fetch: lat=0 acks in REQ, lat=k acks in WAIT cycle k,
    // lat<0 withholds the ack and expects a timeout fault.
    task automatic fetch_one(input int lat, input logic [31:0] data);
        bit ok;
        exp_t e;
        wait_req(ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_wait: got no imem_req expected imem_req within 20 cycles");
            return;
        end
        chk("req_addr", imem_addr, exp_pc);
        if (lat < 0) begin
            imem_ack = 1'b0;
            for (int k = 1; k <= T; k++) begin
                @(negedge clk);
                chk("wait_req_low", {31'h0, imem_req}, 32'h0);
                chk("wait_no_fault", {31'h0, fault}, 32'h0);
            end
            @(negedge clk);
            chk("timeout_fault", {31'h0, fault}, 32'h1);
            chk("timeout_code", {30'h0, fault_code}, 32'h1);
            chk("timeout_req", {31'h0, imem_req}, 32'h0);
            repeat (3) @(negedge clk);
            chk("timeout_sticky_req", {31'h0, imem_req}, 32'h0);
            chk("timeout_sticky_fault", {31'h0, fault}, 32'h1);
            $display("txn timeout pc=%h fault_code=%0d", pc, fault_code);
            return;
        end
        e.pc    = exp_pc;
        e.instr = data;
        exp_q.push_back(e);
        if (lat == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = data;
        end else begin
            imem_ack = 1'b0;
            repeat (lat) @(negedge clk);
            imem_ack   = 1'b1;
            imem_rdata = data;
        end
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("fetch_latency_valid", {31'h0, instr_valid}, 32'h1);
    endtask

    // Retire the held instruction after dly idle HOLD cycles.
    task automatic retire(input int dly, input logic br, input logic z, input logic [31:0] imm);
        logic [31:0] tgt;
        instr_ready = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, instr_valid}, 32'h1);
            chk("hold_pc", pc, exp_pc);
        end
        instr_ready = 1'b1;
        branch      = br;
        zero        = z;
        imm_b       = imm;
        @(negedge clk);
        instr_ready = 1'b0;
        branch      = 1'($urandom);
        zero        = 1'($urandom);
        imm_b       = $urandom;
        tgt = (br && z) ? exp_pc + imm : exp_pc + 32'd4;
        if (tgt % 4 != 0) begin
            chk("misalign_fault", {31'h0, fault}, 32'h1);
            chk("misalign_code", {30'h0, fault_code}, 32'h2);
            chk("misalign_pc", pc, exp_pc);
            chk("misalign_valid", {31'h0, instr_valid}, 32'h0);
            chk("misalign_req", {31'h0, imem_req}, 32'h0);
            $display("txn retire pc=%h target=%h -> fault", exp_pc, tgt);
        end else begin
            $display("txn retire pc=%h br=%0d z=%0d imm=%h -> %h", exp_pc, br, z, imm, tgt);
            exp_pc = tgt;
            chk("retire_next_req", {31'h0, imem_req}, 32'h1);
            chk("retire_next_addr", imem_addr, exp_pc);
        end
    endtask

    // Monitor: compare the held instruction against the scoreboard on each new HOLD.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (instr_valid && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL hold_unexpected: got pc=%h instr=%h expected no held instruction", pc, instr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hold_pc_sb", pc, e.pc);
                        chk("hold_instr_sb", instr, e.instr);
                        chk("hold_opcode_sb", {25'h0, opcode}, {25'h0, e.instr[6:0]});
                        $display("txn fetch pc=%h instr=%h opcode=%b", pc, instr, opcode);
                    end
                end
                prev = instr_valid;
            end
        end
    end

    // Stimulus
    initial begin
        bit ok;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        imm_b       = 32'h0;
        exp_pc      = RPC;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        fetch_one(0, 32'h00A0_0093);
        chk("first_opcode", {25'h0, opcode}, 32'h13);

        // Directed: sequential, wrap, branch taken/not taken
        retire(0, 1'b0, 1'b0, 32'h0);          fetch_one(1, $urandom);
        retire(1, 1'b0, 1'b1, 32'h0);          fetch_one(2, $urandom);
        retire(0, 1'b1, 1'b1, 32'hFFFF_FFF4);  fetch_one(0, $urandom);
        retire(0, 1'b0, 1'b0, 32'h0);          fetch_one(0, $urandom);
        retire(0, 1'b1, 1'b1, 32'h0000_0010); fetch_one(0, $urandom);
        retire(0, 1'b1, 1'b1, 32'hFFFF_FFF8);  fetch_one(1, $urandom);
        retire(0, 1'b1, 1'b1, 32'h0000_0008); fetch_one(0, $urandom);
        retire(2, 1'b1, 1'b0, 32'hFFFF_FFF8);  fetch_one(0, $urandom);

        // Randomized aligned traffic
        for (int n = 0; n < 40; n++) begin
            logic [31:0] imm;
            imm = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
            retire($urandom_range(0, 2), 1'($urandom), 1'($urandom), imm);
            fetch_one($urandom_range(0, T - 1), $urandom);
        end

        // Jump to 0x20 with the ack at the last comfortable WAIT cycle
        retire(0, 1'b1, 1'b1, 32'h20 - exp_pc);
        fetch_one(T - 1, $urandom);
        // Misaligned taken branch, then stray inputs are ignored
        retire(0, 1'b1, 1'b1, 32'h6);
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        chk("fault_sticky", {31'h0, fault}, 32'h1);
        chk("fault_sticky_code", {30'h0, fault_code}, 32'h2);
        chk("fault_sticky_pc", pc, 32'h20);
        chk("fault_sticky_req", {31'h0, imem_req}, 32'h0);

        // Asynchronous reset out of FAULT
        #2 reset = 1'b1;
        #1 chk_reset("async_reset");
        exp_pc = RPC;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        fetch_one(0, $urandom);
        retire(0, 1'b0, 1'b0, 32'h0);
        fetch_one(-1, 32'h0);

        // Reset while waiting in WAIT, then a late ack must be ignored
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_pc = RPC;
        @(negedge clk);
        wait_req(ok);
        chk("wait_reset_req", {31'h0, imem_req}, 32'h1);
        imem_ack = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset("wait_reset");
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        @(negedge clk);
        fetch_one(1, 32'h0030_0113);
        retire(0, 1'b0, 1'b0, 32'h0);
        fetch_one(0, $urandom);
        repeat (2) @(negedge clk);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
